// File: rtl/mmu_uncached_bridge.sv
// mmu_uncached_bridge: single-outstanding bridge from the MMU uncached data port to AXI4-Lite.
// Optional R/B response timeout with late-response drain is enabled by defining UNCACHED_TIMEOUT_EN.
module mmu_uncached_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] data_o,
  output logic        rdy_o,
  output logic [1:0]  exception_o,
  output logic        m_awvalid_o,
  input  logic        m_awready_i,
  output logic [31:0] m_awaddr_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic        m_bvalid_i,
  output logic        m_bready_o,
  input  logic [1:0]  m_bresp_i,
  output logic        m_arvalid_o,
  input  logic        m_arready_i,
  output logic [31:0] m_araddr_o,
  input  logic        m_rvalid_i,
  output logic        m_rready_o,
  input  logic [31:0] m_rdata_i,
  input  logic [1:0]  m_rresp_i
);

`ifdef UNCACHED_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP, DRAIN} state_t;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;
  logic        timed_out;
  logic        rsp_fire;
  assign rsp_fire = (m_rready_o & m_rvalid_i) | (m_bready_o & m_bvalid_i);
`else
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;
  // The timeout length only matters when the timeout logic is built in.
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  state_t state;
  logic   aw_done, w_done;
  logic   aw_fire, w_fire;
  logic   unused_bits;

  assign aw_fire     = m_awvalid_o & m_awready_i;
  assign w_fire      = m_wvalid_o & m_wready_i;
  assign unused_bits = ^{addr_i[1:0], m_rresp_i[0], m_bresp_i[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      data_o      <= '0;
      rdy_o       <= 1'b0;
      exception_o <= '0;
      m_awvalid_o <= 1'b0;
      m_awaddr_o  <= '0;
      m_wvalid_o  <= 1'b0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
      m_bready_o  <= 1'b0;
      m_arvalid_o <= 1'b0;
      m_araddr_o  <= '0;
      m_rready_o  <= 1'b0;
`ifdef UNCACHED_TIMEOUT_EN
      wait_cnt    <= '0;
      timed_out   <= 1'b0;
`endif
    end else begin
      rdy_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_i && rd_i && wr_i) begin
            data_o      <= '0;
            exception_o <= 2'b11;
            rdy_o       <= 1'b1;
            state       <= RESP;
          end else if (sel_i && rd_i) begin
            m_araddr_o  <= {addr_i[31:2], 2'b00};
            m_arvalid_o <= 1'b1;
            state       <= RD_ADDR;
          end else if (sel_i && wr_i) begin
            m_awaddr_o  <= {addr_i[31:2], 2'b00};
            m_wdata_o   <= data_i;
            m_wstrb_o   <= mask_i;
            m_awvalid_o <= 1'b1;
            m_wvalid_o  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= WR_REQ;
          end
        end
        RD_ADDR: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
`ifdef UNCACHED_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid_i) begin
            m_rready_o  <= 1'b0;
            data_o      <= m_rresp_i[1] ? 32'h0 : m_rdata_i;
            exception_o <= m_rresp_i[1] ? 2'b01 : 2'b00;
            rdy_o       <= 1'b1;
            state       <= RESP;
          end
`ifdef UNCACHED_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            data_o      <= '0;
            exception_o <= 2'b01;
            rdy_o       <= 1'b1;
            timed_out   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        // AW and W retire independently; either may finish first or both together.
        WR_REQ: begin
          if (aw_fire) begin
            m_awvalid_o <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_fire) begin
            m_wvalid_o <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            m_bready_o <= 1'b1;
`ifdef UNCACHED_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid_i) begin
            m_bready_o  <= 1'b0;
            data_o      <= '0;
            exception_o <= m_bresp_i[1] ? 2'b10 : 2'b00;
            rdy_o       <= 1'b1;
            state       <= RESP;
          end
`ifdef UNCACHED_TIMEOUT_EN
          else if (wait_cnt == TIMEOUT_LAST) begin
            data_o      <= '0;
            exception_o <= 2'b10;
            rdy_o       <= 1'b1;
            timed_out   <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
`ifdef UNCACHED_TIMEOUT_EN
        // After a timeout the ready stays up so the late response can be swallowed.
        RESP: begin
          if (timed_out && !rsp_fire) begin
            state <= DRAIN;
          end else begin
            m_rready_o <= 1'b0;
            m_bready_o <= 1'b0;
            timed_out  <= 1'b0;
            state      <= IDLE;
          end
        end
        DRAIN: begin
          if (rsp_fire) begin
            m_rready_o <= 1'b0;
            m_bready_o <= 1'b0;
            timed_out  <= 1'b0;
            state      <= IDLE;
          end
        end
`else
        RESP: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_uncached_bridge.sv
// tb_mmu_uncached_bridge: scoreboard bench with a configurable AXI4-Lite slave model.
// Timeout/drain scenario runs only when UNCACHED_TIMEOUT_EN is defined.
module tb_mmu_uncached_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sel_i, rd_i, wr_i;
  logic [31:0] addr_i, data_i;
  logic [3:0]  mask_i;
  logic [31:0] data_o;
  logic        rdy_o;
  logic [1:0]  exception_o;
  logic        m_awvalid_o, m_awready_i;
  logic [31:0] m_awaddr_o;
  logic        m_wvalid_o, m_wready_i;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_bvalid_i, m_bready_o;
  logic [1:0]  m_bresp_i;
  logic        m_arvalid_o, m_arready_i;
  logic [31:0] m_araddr_o;
  logic        m_rvalid_i, m_rready_o;
  logic [31:0] m_rdata_i;
  logic [1:0]  m_rresp_i;

  mmu_uncached_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .rd_i(rd_i), .wr_i(wr_i),
    .addr_i(addr_i), .data_i(data_i), .mask_i(mask_i),
    .data_o(data_o), .rdy_o(rdy_o), .exception_o(exception_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Slave model knobs and observations
  int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
  bit          r_enable = 1'b1;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = '0, b_resp = '0;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0;
  int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  bit          valid_seen = 1'b0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  // Slave decides its handshakes at the falling edge; they take effect on the next rising edge.
  initial begin
    m_arready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
    m_rvalid_i = 1'b0; m_bvalid_i = 1'b0;
    m_rdata_i = '0; m_rresp_i = '0; m_bresp_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        m_arready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
        m_rvalid_i = 1'b0; m_bvalid_i = 1'b0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      end else begin
        if (m_arvalid_o || m_awvalid_o || m_wvalid_o) valid_seen = 1'b1;
        if (m_arvalid_o && ar_cnt >= ar_delay) begin
          m_arready_i = 1'b1; ar_hs++; ar_cnt = 0; last_araddr = m_araddr_o;
        end else begin
          m_arready_i = 1'b0; ar_cnt = m_arvalid_o ? ar_cnt + 1 : 0;
        end
        if (m_awvalid_o && aw_cnt >= aw_delay) begin
          m_awready_i = 1'b1; aw_hs++; aw_cnt = 0; last_awaddr = m_awaddr_o;
        end else begin
          m_awready_i = 1'b0; aw_cnt = m_awvalid_o ? aw_cnt + 1 : 0;
        end
        if (m_wvalid_o && w_cnt >= w_delay) begin
          m_wready_i = 1'b1; w_hs++; w_cnt = 0; last_wdata = m_wdata_o; last_wstrb = m_wstrb_o;
        end else begin
          m_wready_i = 1'b0; w_cnt = m_wvalid_o ? w_cnt + 1 : 0;
        end
        if (m_rready_o && r_enable && r_cnt >= r_delay) begin
          m_rvalid_i = 1'b1; m_rdata_i = r_data; m_rresp_i = r_resp; r_hs++; r_cnt = 0;
        end else begin
          m_rvalid_i = 1'b0; r_cnt = (m_rready_o && r_enable) ? r_cnt + 1 : 0;
        end
        if (m_bready_o && b_cnt >= b_delay) begin
          m_bvalid_i = 1'b1; m_bresp_i = b_resp; b_hs++; b_cnt = 0;
        end else begin
          m_bvalid_i = 1'b0; b_cnt = m_bready_o ? b_cnt + 1 : 0;
        end
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask);
    @(posedge clk_i);
    #1;
    sel_i = 1'b1; rd_i = rd; wr_i = wr; addr_i = addr; data_i = data; mask_i = mask;
  endtask

  // Cycle 0 is the cycle the request is first presented; request drops as soon as rdy_o is seen.
  task automatic wait_rdy(output int lat, output logic [31:0] d, output logic [1:0] e, output bit ok);
    ok = 1'b0; lat = -1; d = '0; e = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      if (rdy_o) begin
        lat = c; d = data_o; e = exception_o; ok = 1'b1;
        break;
      end
    end
    sel_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    n_cmp++;
    if ({m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o, rdy_o} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_handshake: got %b expected 000000",
               {m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o, rdy_o});
    end
    n_cmp++;
    if ({m_araddr_o, m_awaddr_o, m_wdata_o, m_wstrb_o} !== 100'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_bus_regs: got %h expected 0", {m_araddr_o, m_awaddr_o, m_wdata_o, m_wstrb_o});
    end
    n_cmp++;
    if ({data_o, exception_o} !== 34'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mmu_regs: got %h expected 0", {data_o, exception_o});
    end
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_read_zero_wait();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok; int ar0;
    ar0 = ar_hs; r_data = 32'hDEAD_BEEF; r_resp = 2'b00;
    sb.push_back('{32'hDEAD_BEEF, 2'b00, 3});
    issue(1'b1, 1'b0, 32'h2000_0106, 32'h0, 4'h0);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rd0_rdy_seen: got %b expected 1", ok); end
    n_cmp++; if (d !== x.data) begin n_fail++; $display("[TB] FAIL rd0_data: got %h expected %h", d, x.data); end
    n_cmp++; if (e !== x.exc) begin n_fail++; $display("[TB] FAIL rd0_exc: got %b expected %b", e, x.exc); end
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL rd0_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (last_araddr !== 32'h2000_0104) begin n_fail++; $display("[TB] FAIL rd0_araddr: got %h expected 20000104", last_araddr); end
    n_cmp++; if (ar_hs - ar0 !== 1) begin n_fail++; $display("[TB] FAIL rd0_ar_count: got %0d expected 1", ar_hs - ar0); end
    @(negedge clk_i);
    n_cmp++; if (rdy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rd0_rdy_pulse: got %b expected 0", rdy_o); end
  endtask

  task automatic test_write_w_late();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok; int aw0, w0;
    aw0 = aw_hs; w0 = w_hs; aw_delay = 0; w_delay = 2; b_resp = 2'b00;
    sb.push_back('{32'h0, 2'b00, 5});
    issue(1'b0, 1'b1, 32'h4000_0013, 32'h1234_5678, 4'b0011);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    w_delay = 0;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_rdy_seen: got %b expected 1", ok); end
    n_cmp++; if (e !== x.exc) begin n_fail++; $display("[TB] FAIL wr_exc: got %b expected %b", e, x.exc); end
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL wr_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (last_wstrb !== 4'b0011) begin n_fail++; $display("[TB] FAIL wr_wstrb: got %b expected 0011", last_wstrb); end
    n_cmp++; if (last_wdata !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL wr_wdata: got %h expected 12345678", last_wdata); end
    n_cmp++; if (last_awaddr !== 32'h4000_0010) begin n_fail++; $display("[TB] FAIL wr_awaddr: got %h expected 40000010", last_awaddr); end
    n_cmp++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
      n_fail++; $display("[TB] FAIL wr_hs_count: got aw=%0d w=%0d expected 1/1", aw_hs - aw0, w_hs - w0);
    end
  endtask

  task automatic test_faults();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok;
    r_data = 32'h1111_1111; r_resp = 2'b10;
    sb.push_back('{32'h0, 2'b01, 3});
    issue(1'b1, 1'b0, 32'h2000_0200, 32'h0, 4'h0);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    r_resp = 2'b00;
    n_cmp++; if (d !== x.data) begin n_fail++; $display("[TB] FAIL rdfault_data: got %h expected %h", d, x.data); end
    n_cmp++; if (e !== x.exc) begin n_fail++; $display("[TB] FAIL rdfault_exc: got %b expected %b", e, x.exc); end
    b_resp = 2'b11;
    sb.push_back('{32'h0, 2'b10, 3});
    issue(1'b0, 1'b1, 32'h4000_0200, 32'hFFFF_0000, 4'b1111);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    b_resp = 2'b00;
    n_cmp++; if (e !== x.exc) begin n_fail++; $display("[TB] FAIL wrfault_exc: got %b expected %b", e, x.exc); end
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL wrfault_latency: got %0d expected %0d", lat, x.lat); end
  endtask

  task automatic test_both_requests();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok;
    valid_seen = 1'b0;
    sb.push_back('{32'h0, 2'b11, 1});
    issue(1'b1, 1'b1, 32'h2000_0300, 32'h5555_5555, 4'hF);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    repeat (3) @(negedge clk_i);
    n_cmp++; if (e !== x.exc) begin n_fail++; $display("[TB] FAIL both_exc: got %b expected %b", e, x.exc); end
    n_cmp++; if (d !== x.data) begin n_fail++; $display("[TB] FAIL both_data: got %h expected %h", d, x.data); end
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL both_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (valid_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL both_no_bus: got %b expected 0", valid_seen); end
  endtask

  task automatic test_reset_mid();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok; bit reached;
    r_enable = 1'b0; reached = 1'b0;
    issue(1'b1, 1'b0, 32'h3000_0008, 32'h0, 4'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (m_rready_o) begin reached = 1'b1; break; end
    end
    n_cmp++; if (reached !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_rd_data: got %b expected 1", reached); end
    rst_i = 1'b1; sel_i = 1'b0; rd_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o, rdy_o, m_araddr_o} !== 38'b0) begin
      n_fail++; $display("[TB] FAIL rst_mid_outputs: got %h expected 0",
                         {m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o, rdy_o, m_araddr_o});
    end
    rst_i = 1'b0; r_enable = 1'b1; r_delay = 2; r_data = 32'hCAFE_F00D;
    sb.push_back('{32'hCAFE_F00D, 2'b00, 5});
    issue(1'b1, 1'b0, 32'h3000_000C, 32'h0, 4'h0);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    r_delay = 0;
    n_cmp++; if (d !== x.data) begin n_fail++; $display("[TB] FAIL rst_after_data: got %h expected %h", d, x.data); end
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL rst_after_latency: got %0d expected %0d", lat, x.lat); end
  endtask

  task automatic test_back_to_back();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok; int w0;
    ar_delay = 1;
    sb.push_back('{32'hA000_0001, 2'b00, 4});
    sb.push_back('{32'hB000_0002, 2'b00, 4});
    sb.push_back('{32'h0, 2'b00, 3});
    for (int i = 0; i < 2; i++) begin
      r_data = (i == 0) ? 32'hA000_0001 : 32'hB000_0002;
      issue(1'b1, 1'b0, 32'h2000_1000 + 32'(i * 4), 32'h0, 4'h0);
      wait_rdy(lat, d, e, ok);
      x = sb.pop_front();
      n_cmp++; if (d !== x.data) begin n_fail++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, d, x.data); end
      n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL b2b_latency%0d: got %0d expected %0d", i, lat, x.lat); end
    end
    ar_delay = 0;
    w0 = w_hs;
    issue(1'b0, 1'b1, 32'h4000_0020, 32'h0BAD_0BAD, 4'b0000);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL mask0_latency: got %0d expected %0d", lat, x.lat); end
    n_cmp++; if (w_hs - w0 !== 1 || last_wstrb !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL mask0_issued: got w=%0d strb=%b expected 1/0000", w_hs - w0, last_wstrb);
    end
  endtask

`ifdef UNCACHED_TIMEOUT_EN
  task automatic test_timeout_drain();
    exp_t x; int lat; logic [31:0] d; logic [1:0] e; bit ok; int ar0;
    r_enable = 1'b0; r_data = 32'hA5A5_A5A5;
    sb.push_back('{32'h0, 2'b01, 6});
    issue(1'b1, 1'b0, 32'h5000_0000, 32'h0, 4'h0);
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    n_cmp++; if (e !== x.exc) begin n_fail++; $display("[TB] FAIL to_exc: got %b expected %b", e, x.exc); end
    n_cmp++; if (d !== x.data) begin n_fail++; $display("[TB] FAIL to_data: got %h expected %h", d, x.data); end
    n_cmp++; if (lat !== x.lat) begin n_fail++; $display("[TB] FAIL to_latency: got %0d expected %0d", lat, x.lat); end
    ar0 = ar_hs;
    sb.push_back('{32'hA5A5_A5A5, 2'b00, -1});
    issue(1'b1, 1'b0, 32'h5000_0004, 32'h0, 4'h0);
    repeat (6) @(negedge clk_i);
    n_cmp++; if (ar_hs - ar0 !== 0 || m_arvalid_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL to_stall: got ar=%0d arvalid=%b expected 0/0", ar_hs - ar0, m_arvalid_o);
    end
    r_enable = 1'b1;
    wait_rdy(lat, d, e, ok);
    x = sb.pop_front();
    n_cmp++; if (d !== x.data || e !== x.exc) begin
      n_fail++; $display("[TB] FAIL to_after_drain: got %h/%b expected %h/%b", d, e, x.data, x.exc);
    end
    n_cmp++; if (ar_hs - ar0 !== 1) begin n_fail++; $display("[TB] FAIL to_ar_count: got %0d expected 1", ar_hs - ar0); end
  endtask
`endif

  initial begin
    rst_i = 1'b1; sel_i = 1'b0; rd_i = 1'b0; wr_i = 1'b0;
    addr_i = '0; data_i = '0; mask_i = '0;
    repeat (3) @(posedge clk_i);
    test_reset();
    test_read_zero_wait();
    test_write_w_late();
    test_faults();
    test_both_requests();
    test_reset_mid();
    test_back_to_back();
`ifdef UNCACHED_TIMEOUT_EN
    test_timeout_drain();
`endif
    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
